// File: rtl/exp_ctrl_pkg.sv
// Shared types and constants for the Q8.8 exp() series controller.
// States are one-hot so every control output is a direct flop decode.
package exp_ctrl_pkg;

    localparam int          ROM_DEPTH = 8;
    localparam logic [15:0] ONE       = 16'h0100;

    localparam int B_IDLE  = 0;
    localparam int B_LOAD  = 1;
    localparam int B_MUL_X = 2;
    localparam int B_MUL_C = 3;
    localparam int B_ACC   = 4;
    localparam int B_DONE  = 5;

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        LOAD  = 6'b000010,
        MUL_X = 6'b000100,
        MUL_C = 6'b001000,
        ACC   = 6'b010000,
        DONE  = 6'b100000
    } state_t;

endpackage

// File: rtl/exp_term_counter.sv
// Series term index: cleared on load/finish, advanced once per term.
// Saturates at the last legal index; it never wraps.
module exp_term_counter #(
    parameter int MAX_TERMS = 8,
    parameter int IDX_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_TERMS - 1);

    logic [IDX_W-1:0] r_idx;

    // index register: clear wins over increment, hold at the last term
    always_ff @(posedge clk) begin
        if (rst || clr)
            r_idx <= '0;
        else if (inc && !last)
            r_idx <= r_idx + 1'b1;
    end

    assign last = (r_idx == LAST_IDX);
    assign idx  = r_idx;

endmodule

// File: rtl/exp_series_ctrl.sv
// Controller FSM sequencing the Q8.8 exp() series datapath.
// Optional: EXP_ALT_SIGN_EN adds port neg; odd terms subtract (exp(-x)).
module exp_series_ctrl
    import exp_ctrl_pkg::*;
#(
    parameter int MAX_TERMS = 8,
    parameter int IDX_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef EXP_ALT_SIGN_EN
    input  logic             neg,
`endif
    input  logic             less_cmp,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             ld_x,
    output logic             s4_in,
    output logic             s4_mult,
    output logic             ld_y,
    output logic             init_tmp,
    output logic             init_ans,
    output logic             ld_tmp,
    output logic             ld_ans,
    output logic             s1_rom,
    output logic             s1_x,
    output logic             s2_tmp,
    output logic             s2_x,
    output logic [IDX_W-1:0] s3,
    output logic             sub
);

    // the ROM cannot supply more coefficients than it holds
    localparam int TERMS = (MAX_TERMS > ROM_DEPTH) ? ROM_DEPTH : MAX_TERMS;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] w_idx;
    logic             w_last;
    logic             w_clr;
    logic             w_inc;

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // next-state logic; less_cmp only matters while accumulating
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    w_next = MUL_X;
            MUL_X:   w_next = MUL_C;
            MUL_C:   w_next = ACC;
            ACC:     w_next = (less_cmp || w_last) ? DONE : MUL_X;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_clr = r_state[B_LOAD] | r_state[B_DONE];
    assign w_inc = r_state[B_ACC] & ~less_cmp;

    exp_term_counter #(
        .MAX_TERMS (TERMS),
        .IDX_W     (IDX_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .inc  (w_inc),
        .idx  (w_idx),
        .last (w_last)
    );

    // control outputs are pure decodes of single state flops
    assign ready    = r_state[B_IDLE];
    assign busy     = r_state[B_LOAD] | r_state[B_MUL_X]
                    | r_state[B_MUL_C] | r_state[B_ACC];
    assign done     = r_state[B_DONE];
    assign ld_x     = r_state[B_LOAD];
    assign s4_in    = r_state[B_LOAD];
    assign s4_mult  = 1'b0;
    assign ld_y     = r_state[B_LOAD];
    assign init_tmp = r_state[B_LOAD];
    assign init_ans = r_state[B_LOAD];
    assign ld_tmp   = r_state[B_MUL_X] | r_state[B_MUL_C];
    assign ld_ans   = r_state[B_ACC];
    assign s1_rom   = r_state[B_MUL_C];
    assign s1_x     = r_state[B_MUL_X];
    assign s2_tmp   = r_state[B_MUL_X] | r_state[B_MUL_C];
    assign s2_x     = 1'b0;
    assign s3       = w_idx;

`ifdef EXP_ALT_SIGN_EN
    logic r_neg_q;

    // capture the sign request when a computation is accepted
    always_ff @(posedge clk) begin
        if (rst)
            r_neg_q <= 1'b0;
        else if (start && r_state[B_IDLE])
            r_neg_q <= neg;
    end

    assign sub = r_state[B_ACC] & r_neg_q & ~w_idx[0];
`else
    assign sub = 1'b0;
`endif

endmodule

// File: tb/tb_exp_series_ctrl.sv
// Self-checking bench for exp_series_ctrl (MAX_TERMS=8).
// Expected done offsets go to a scoreboard queue at each accepted start.
module tb_exp_series_ctrl;

    localparam int MT = 8;
    localparam int IW = 8;
`ifdef EXP_ALT_SIGN_EN
    localparam bit ALT = 1'b1;
`else
    localparam bit ALT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          neg;
    logic          less_cmp;
    logic          ready, busy, done, ld_x, s4_in, s4_mult, ld_y;
    logic          init_tmp, init_ans, ld_tmp, ld_ans;
    logic          s1_rom, s1_x, s2_tmp, s2_x, sub;
    logic [IW-1:0] s3;
    logic [15:0]   obs;

    int total = 0;
    int bad   = 0;
    int exp_done_q[$];

    typedef struct {
        int stopk;
        int hold;
        int ng;
    } run_t;

    always #5 clk = ~clk;

    assign obs = {ready, busy, done, ld_x, s4_in, s4_mult, ld_y,
                  init_tmp, init_ans, ld_tmp, ld_ans,
                  s1_rom, s1_x, s2_tmp, s2_x, sub};

    exp_series_ctrl #(.MAX_TERMS(MT), .IDX_W(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef EXP_ALT_SIGN_EN
        .neg      (neg),
`endif
        .less_cmp (less_cmp),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .ld_x     (ld_x),
        .s4_in    (s4_in),
        .s4_mult  (s4_mult),
        .ld_y     (ld_y),
        .init_tmp (init_tmp),
        .init_ans (init_ans),
        .ld_tmp   (ld_tmp),
        .ld_ans   (ld_ans),
        .s1_rom   (s1_rom),
        .s1_x     (s1_x),
        .s2_tmp   (s2_tmp),
        .s2_x     (s2_x),
        .s3       (s3),
        .sub      (sub)
    );

    // Expected output vector o cycles after LOAD for an n-term run.
    // Bits: ready busy done ld_x s4_in s4_mult ld_y init_tmp init_ans
    //       ld_tmp ld_ans s1_rom s1_x s2_tmp s2_x sub
    function automatic logic [15:0] exp_vec(int o, int n, logic ng);
        logic [15:0] v;
        int k, ph;
        v = '0;
        if (o == 0) begin
            v[14] = 1'b1; v[12] = 1'b1; v[11] = 1'b1;
            v[9]  = 1'b1; v[8]  = 1'b1; v[7]  = 1'b1;
        end else if (o <= 3 * n) begin
            k  = (o - 1) / 3;
            ph = (o - 1) % 3;
            v[14] = 1'b1;
            if (ph == 0) begin
                v[6] = 1'b1; v[3] = 1'b1; v[2] = 1'b1;
            end else if (ph == 1) begin
                v[6] = 1'b1; v[4] = 1'b1; v[2] = 1'b1;
            end else begin
                v[5] = 1'b1;
                v[0] = ALT && (ng === 1'b1) && (k % 2 == 0);
            end
        end else if (o == 3 * n + 1) begin
            v[13] = 1'b1;
        end else begin
            v[15] = 1'b1;
        end
        return v;
    endfunction

    function automatic int exp_s3(int o, int n);
        if (o >= 1 && o <= 3 * n) return (o - 1) / 3;
        if (o == 3 * n + 1)       return n - 1;
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; neg = 1'b0; less_cmp = 1'b0;
        tick();
        tick();
        total++;
        if (obs !== 16'h8000 || s3 !== '0) begin
            bad++;
            $display("FAIL reset_hold vec=%h s3=%0d need vec=8000 s3=0", obs, s3);
        end
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (obs !== 16'h8000 || s3 !== '0) begin
            bad++;
            $display("FAIL reset_release vec=%h s3=%0d need vec=8000 s3=0", obs, s3);
        end
    endtask

    // Single runs: hold=1 keeps less_cmp high all run; else stopk picks
    // the ACC (1-based) where less_cmp pulses, 0 meaning never.
    task automatic test_runs();
        run_t tbl [6];
        int   n, e, nld, ninit, nd;
        tbl = '{'{1, 1, 0}, '{0, 0, 0}, '{3, 0, 0},
                '{0, 0, 1}, '{4, 0, 1}, '{0, 0, 0}};
        foreach (tbl[r]) begin
            n = (tbl[r].hold != 0) ? 1 : ((tbl[r].stopk == 0) ? MT : tbl[r].stopk);
            start = 1'b1;
            neg   = (tbl[r].ng != 0);
            tick();
            start = 1'b0;
            exp_done_q.push_back(3 * n + 1);
            nld = 0; ninit = 0; nd = 0;
            for (int o = 0; o <= 3 * n + 2; o++) begin
                less_cmp = (tbl[r].hold != 0) ||
                           (tbl[r].stopk != 0 && o == 3 * tbl[r].stopk);
                total++;
                if (obs !== exp_vec(o, n, neg) || s3 !== IW'(exp_s3(o, n))) begin
                    bad++;
                    $display("FAIL run%0d o=%0d vec=%h s3=%0d need vec=%h s3=%0d",
                             r, o, obs, s3, exp_vec(o, n, neg), exp_s3(o, n));
                end
                if (ld_ans)   nld++;
                if (init_tmp) ninit++;
                if (done) begin
                    nd++;
                    total++;
                    if (exp_done_q.size() == 0) begin
                        bad++;
                        $display("FAIL run%0d_done o=%0d unexpected done", r, o);
                    end else begin
                        e = exp_done_q.pop_front();
                        if (o != e) begin
                            bad++;
                            $display("FAIL run%0d_done_lat got=%0d need=%0d", r, o, e);
                        end
                    end
                end
                tick();
            end
            less_cmp = 1'b0;
            neg      = 1'b0;
            total++;
            if (nld != n || ninit != 1 || nd != 1 || exp_done_q.size() != 0) begin
                bad++;
                $display("FAIL run%0d_counts ld_ans=%0d init=%0d done=%0d left=%0d need %0d/1/1/0",
                         r, nld, ninit, nd, exp_done_q.size(), n);
                exp_done_q.delete();
            end
        end
    endtask

    task automatic test_mid_reset();
        int nd, e;
        less_cmp = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_done_q.push_back(3 * MT + 1);
        for (int o = 0; o <= 5; o++) begin
            total++;
            if (obs !== exp_vec(o, MT, 1'b0) || s3 !== IW'(exp_s3(o, MT))) begin
                bad++;
                $display("FAIL midrst_pre o=%0d vec=%h s3=%0d need vec=%h s3=%0d",
                         o, obs, s3, exp_vec(o, MT, 1'b0), exp_s3(o, MT));
            end
            if (o == 5) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        exp_done_q.delete();
        total++;
        if (obs !== 16'h8000 || s3 !== '0) begin
            bad++;
            $display("FAIL midrst_idle vec=%h s3=%0d need vec=8000 s3=0", obs, s3);
        end
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            if (done || !ready) nd++;
            tick();
        end
        total++;
        if (nd != 0) begin
            bad++;
            $display("FAIL midrst_quiet active_cycles=%0d need=0", nd);
        end
        less_cmp = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_done_q.push_back(4);
        for (int o = 0; o <= 5; o++) begin
            total++;
            if (obs !== exp_vec(o, 1, 1'b0) || s3 !== IW'(exp_s3(o, 1))) begin
                bad++;
                $display("FAIL midrst_restart o=%0d vec=%h s3=%0d need vec=%h s3=%0d",
                         o, obs, s3, exp_vec(o, 1, 1'b0), exp_s3(o, 1));
            end
            if (done) begin
                total++;
                e = (exp_done_q.size() != 0) ? exp_done_q.pop_front() : -1;
                if (o != e) begin
                    bad++;
                    $display("FAIL midrst_done_lat got=%0d need=%0d", o, e);
                end
            end
            tick();
        end
        less_cmp = 1'b0;
        total++;
        if (exp_done_q.size() != 0) begin
            bad++;
            $display("FAIL midrst_missing_done left=%0d need=0", exp_done_q.size());
            exp_done_q.delete();
        end
    endtask

    task automatic test_ignored_start();
        int n, nd, e, nbad;
        n = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_done_q.push_back(3 * n + 1);
        nd = 0;
        for (int o = 0; o <= 3 * n + 2; o++) begin
            start    = (o == 1) || (o == 3 * n + 1);
            less_cmp = (o == 3 * n);
            total++;
            if (obs !== exp_vec(o, n, 1'b0) || s3 !== IW'(exp_s3(o, n))) begin
                bad++;
                $display("FAIL ignstart o=%0d vec=%h s3=%0d need vec=%h s3=%0d",
                         o, obs, s3, exp_vec(o, n, 1'b0), exp_s3(o, n));
            end
            if (done) begin
                nd++;
                total++;
                e = (exp_done_q.size() != 0) ? exp_done_q.pop_front() : -1;
                if (o != e) begin
                    bad++;
                    $display("FAIL ignstart_done_lat got=%0d need=%0d", o, e);
                end
            end
            tick();
        end
        start = 1'b0;
        less_cmp = 1'b0;
        nbad = 0;
        for (int i = 0; i < 6; i++) begin
            if (!ready || done || busy) nbad++;
            tick();
        end
        total++;
        if (nd != 1 || nbad != 0 || exp_done_q.size() != 0) begin
            bad++;
            $display("FAIL ignstart_once done=%0d stray=%0d need done=1 stray=0", nd, nbad);
            exp_done_q.delete();
        end
    endtask

    // start held high: runs repeat every 6 cycles with one IDLE between
    task automatic test_back_to_back();
        int nd, e;
        less_cmp = 1'b1;
        start = 1'b1;
        tick();
        exp_done_q.push_back(4);
        exp_done_q.push_back(10);
        exp_done_q.push_back(16);
        nd = 0;
        for (int o = 0; o <= 17; o++) begin
            start = (o < 17);
            total++;
            if (obs !== exp_vec(o % 6, 1, 1'b0) || s3 !== '0) begin
                bad++;
                $display("FAIL b2b o=%0d vec=%h s3=%0d need vec=%h s3=0",
                         o, obs, s3, exp_vec(o % 6, 1, 1'b0));
            end
            if (done) begin
                nd++;
                total++;
                e = (exp_done_q.size() != 0) ? exp_done_q.pop_front() : -1;
                if (o != e) begin
                    bad++;
                    $display("FAIL b2b_done_lat got=%0d need=%0d", o, e);
                end
            end
            tick();
        end
        start = 1'b0;
        less_cmp = 1'b0;
        tick();
        total++;
        if (nd != 3 || !ready || exp_done_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_count done=%0d ready=%b need done=3 ready=1", nd, ready);
            exp_done_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_runs();
        test_mid_reset();
        test_ignored_start();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
